// File: rtl/audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// audio_dac_serializer
//
// I2S master transmitter for the codec DAC port. Runs from the 12.288 MHz
// audio PLL clock, derives BCLK and DACLRCK from it, and shifts one stereo
// sample pair per frame out on DACDAT (MSB first, one-bit I2S delay after
// each LRCLK edge). Sample pairs arrive through a one-deep holding register
// with a valid/ready handshake; a frame that starts with the holding register
// empty sends silence and is counted as an underrun.
//
// Ports:
//   clk            audio clock (PLL outclk_0)
//   rst_n          asynchronous active-low reset
//   pll_locked     PLL lock, asynchronous to clk (synchronised internally)
//   left_data      left sample, two's complement, DATA_WIDTH bits
//   right_data     right sample, two's complement, DATA_WIDTH bits
//   sample_valid   upstream sample pair valid
//   sample_ready   holding register empty and serializer running
//   bclk           bit clock (BCLK_DIV clk cycles per period)
//   lrclk          word select: 0 = left slot, 1 = right slot
//   dacdat         serial data, changes on falling bclk
//   underrun       one-clk pulse when a frame starts with no sample held
//   underrun_count saturating 16-bit count of underruns
// -----------------------------------------------------------------------------
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic [DATA_WIDTH-1:0] right_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  dacdat,
    output logic                  underrun,
    output logic [15:0]           underrun_count
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = $clog2(BCLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN  = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic                    lock_meta_reg, lock_s_reg;
    logic [DIV_W-1:0]        div_reg, div_next;
    logic [BIT_W-1:0]        bit_reg, bit_next;
    logic                    hold_full_reg, hold_full_next;
    logic [DATA_WIDTH-1:0]   hold_left_reg, hold_left_next;
    logic [DATA_WIDTH-1:0]   hold_right_reg, hold_right_next;
    logic [DATA_WIDTH-1:0]   shift_left_reg, shift_left_next;
    logic [DATA_WIDTH-1:0]   shift_right_reg, shift_right_next;
    logic                    ready_reg, ready_next;
    logic                    bclk_reg, bclk_next;
    logic                    lrclk_reg, lrclk_next;
    logic                    dacdat_reg, dacdat_next;
    logic                    underrun_reg, underrun_next;
    logic [15:0]             underrun_count_reg, underrun_count_next;

    logic                    fall;
    logic                    frame_start;
    logic                    channel;
    logic [BIT_W-1:0]        slot_bit;
    logic                    xfer;

    // Two-flop synchroniser for the PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            lock_meta_reg <= pll_locked;
            lock_s_reg    <= lock_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            div_reg            <= '0;
            bit_reg            <= BIT_LAST;
            hold_full_reg      <= 1'b0;
            hold_left_reg      <= '0;
            hold_right_reg     <= '0;
            shift_left_reg     <= '0;
            shift_right_reg    <= '0;
            ready_reg          <= 1'b0;
            bclk_reg           <= 1'b0;
            lrclk_reg          <= 1'b0;
            dacdat_reg         <= 1'b0;
            underrun_reg       <= 1'b0;
            underrun_count_reg <= '0;
        end else begin
            state_reg          <= state_next;
            div_reg            <= div_next;
            bit_reg            <= bit_next;
            hold_full_reg      <= hold_full_next;
            hold_left_reg      <= hold_left_next;
            hold_right_reg     <= hold_right_next;
            shift_left_reg     <= shift_left_next;
            shift_right_reg    <= shift_right_next;
            ready_reg          <= ready_next;
            bclk_reg           <= bclk_next;
            lrclk_reg          <= lrclk_next;
            dacdat_reg         <= dacdat_next;
            underrun_reg       <= underrun_next;
            underrun_count_reg <= underrun_count_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        div_next            = div_reg;
        bit_next            = bit_reg;
        hold_full_next      = hold_full_reg;
        hold_left_next      = hold_left_reg;
        hold_right_next     = hold_right_reg;
        shift_left_next     = shift_left_reg;
        shift_right_next    = shift_right_reg;
        lrclk_next          = lrclk_reg;
        dacdat_next         = dacdat_reg;
        underrun_next       = 1'b0;
        underrun_count_next = underrun_count_reg;
        fall                = 1'b0;
        frame_start         = 1'b0;
        channel             = 1'b0;
        slot_bit            = '0;
        // ready_reg is only ever high in RUN, so no transfer can occur in IDLE.
        xfer                = sample_valid & ready_reg;

        case (state_reg)
            IDLE:    if (lock_s_reg)  state_next = RUN;
            RUN:     if (!lock_s_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (state_next == IDLE) begin
            // Lock lost (or never gained): abandon the frame, drop any held pair.
            div_next         = '0;
            bit_next         = BIT_LAST;
            hold_full_next   = 1'b0;
            shift_left_next  = '0;
            shift_right_next = '0;
            lrclk_next       = 1'b0;
            dacdat_next      = 1'b0;
        end else if (state_reg == RUN) begin
            // The entry cycle keeps the idle counter values, which places the
            // first falling event (and frame start) BCLK_DIV clk after entry.
            if (div_reg == DIV_LAST) begin
                div_next = '0;
                fall     = 1'b1;
            end else begin
                div_next = div_reg + DIV_W'(1);
            end

            if (fall) begin
                bit_next    = (bit_reg == BIT_LAST) ? '0 : bit_reg + BIT_W'(1);
                frame_start = (bit_reg == BIT_LAST);
                channel     = (bit_next >= SLOT_LEN);
                slot_bit    = channel ? bit_next - SLOT_LEN : bit_next;
                lrclk_next  = channel;
                dacdat_next = 1'b0;

                if (frame_start) begin
                    if (hold_full_reg) begin
                        shift_left_next  = hold_left_reg;
                        shift_right_next = hold_right_reg;
                        hold_full_next   = 1'b0;
                    end else begin
                        shift_left_next  = '0;
                        shift_right_next = '0;
                        underrun_next    = 1'b1;
                        if (underrun_count_reg != 16'hFFFF)
                            underrun_count_next = underrun_count_reg + 16'd1;
                    end
                end else if (slot_bit >= BIT_W'(1) && slot_bit <= DATA_LAST) begin
                    // Slot bit 0 is the I2S one-bit delay; data bits follow MSB first.
                    if (channel) begin
                        dacdat_next      = shift_right_reg[DATA_WIDTH-1];
                        shift_right_next = shift_right_reg << 1;
                    end else begin
                        dacdat_next      = shift_left_reg[DATA_WIDTH-1];
                        shift_left_next  = shift_left_reg << 1;
                    end
                end
            end

            // Evaluated after the frame-start copy so a transfer landing on an
            // underrun frame start is kept for the following frame.
            if (xfer) begin
                hold_full_next  = 1'b1;
                hold_left_next  = left_data;
                hold_right_next = right_data;
            end
        end

        ready_next = (state_next == RUN) && !hold_full_next;
        bclk_next  = (state_next == RUN) && (div_next >= DIV_HALF);
    end

    assign sample_ready   = ready_reg;
    assign bclk           = bclk_reg;
    assign lrclk          = lrclk_reg;
    assign dacdat         = dacdat_reg;
    assign underrun       = underrun_reg;
    assign underrun_count = underrun_count_reg;

endmodule
